// File: rtl/ray_dispatch_pkg.sv
// Shared ray types: fixed-point/vec3, the pixel-result record and the dispatcher state enum.
package ray_dispatch_pkg;

    localparam int RAY_FRAC_BITS  = 12;
    localparam int RAY_H_BITS     = 9;
    localparam int RAY_V_BITS     = 9;
    localparam int RAY_COLOR_BITS = 4;

    typedef logic signed [15:0] fixed_t;

    typedef struct packed {
        fixed_t x;
        fixed_t y;
        fixed_t z;
    } vec3_t;

    typedef struct packed {
        logic [RAY_H_BITS-1:0]     h;
        logic [RAY_V_BITS-1:0]     v;
        logic [RAY_COLOR_BITS-1:0] color;
    } pix_result_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_DONE     = 2'd3
    } ray_state_t;

endpackage

// File: rtl/ray_dispatch_rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr_i wins, returned as one-hot grant and index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] idx_o
);

    logic found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[(int'(ptr_i) + i) % N]) begin
                found                            = 1'b1;
                grant_o[(int'(ptr_i) + i) % N]   = 1'b1;
                idx_o                            = PW'((int'(ptr_i) + i) % N);
            end
        end
    end

endmodule

// File: rtl/ray_dispatch.sv
// Frame dispatcher: hands raster-order pixel jobs to ray units and funnels their results to one stream.
// state    | meaning
// IDLE     | waiting for start_in
// DISPATCH | issuing one pixel job per cycle to a free unit
// DRAIN    | all pixels issued, waiting for outstanding results to leave
// DONE     | one-cycle frame_done_out pulse
module ray_dispatch
    import ray_dispatch_pkg::*;
#(
    parameter int DISPLAY_WIDTH  = 400,
    parameter int DISPLAY_HEIGHT = 300,
    parameter int H_BITS         = RAY_H_BITS,
    parameter int V_BITS         = RAY_V_BITS,
    parameter int NUM_UNITS      = 4,
    parameter int COLOR_BITS     = RAY_COLOR_BITS
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             start_in,
    input  logic [2:0]                       fractal_sel_in,
    output logic                             busy_out,
    output logic                             frame_done_out,
    output logic [NUM_UNITS-1:0]             unit_valid_out,
    output logic [H_BITS-1:0]                unit_hcount_out,
    output logic [V_BITS-1:0]                unit_vcount_out,
    output logic [2:0]                       unit_fractal_sel_out,
    input  logic [NUM_UNITS-1:0]             unit_ready_in,
    input  logic [NUM_UNITS-1:0]             unit_done_in,
    input  logic [NUM_UNITS*H_BITS-1:0]      unit_hcount_in,
    input  logic [NUM_UNITS*V_BITS-1:0]      unit_vcount_in,
    input  logic [NUM_UNITS*COLOR_BITS-1:0]  unit_color_in,
    output logic                             pix_valid_out,
    input  logic                             pix_ready_in,
    output logic [H_BITS-1:0]                pix_hcount_out,
    output logic [V_BITS-1:0]                pix_vcount_out,
    output logic [COLOR_BITS-1:0]            pix_color_out
);

    localparam int PW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    ray_state_t            state_q, state_d;
    logic [2:0]            sel_q, sel_d;
    logic [H_BITS-1:0]     h_q, h_d, hbus_q, hbus_d;
    logic [V_BITS-1:0]     v_q, v_d, vbus_q, vbus_d;
    logic [PW-1:0]         rr_q, rr_d, op_q, op_d, hold_idx_q, hold_idx_d;
    logic                  hold_q, hold_d;
    logic [NUM_UNITS-1:0]  busy_q, busy_d, full_q, full_d, valid_q, valid_d;
    pix_result_t           res_q [NUM_UNITS];
    pix_result_t           res_d [NUM_UNITS];

    logic [NUM_UNITS-1:0]  iss_req, iss_gnt, out_gnt;
    logic [PW-1:0]         iss_idx, out_arb_idx, out_idx;
    logic                  iss_any, out_any, pix_fire, last_pix;

    assign iss_req = unit_ready_in & ~busy_q;
    assign iss_any = |iss_gnt;
    assign out_any = |out_gnt;

    rr_arbiter #(.N(NUM_UNITS), .PW(PW)) u_issue_arb (
        .req_i   (iss_req),
        .ptr_i   (rr_q),
        .grant_o (iss_gnt),
        .idx_o   (iss_idx)
    );

    rr_arbiter #(.N(NUM_UNITS), .PW(PW)) u_out_arb (
        .req_i   (full_q),
        .ptr_i   (op_q),
        .grant_o (out_gnt),
        .idx_o   (out_arb_idx)
    );

    // A presented but unaccepted result stays locked so a newer capture cannot displace it.
    assign out_idx        = hold_q ? hold_idx_q : out_arb_idx;
    assign pix_valid_out  = hold_q | out_any;
    assign pix_fire       = pix_valid_out & pix_ready_in;
    assign pix_hcount_out = H_BITS'(res_q[out_idx].h);
    assign pix_vcount_out = V_BITS'(res_q[out_idx].v);
    assign pix_color_out  = COLOR_BITS'(res_q[out_idx].color);

    assign busy_out             = (state_q == ST_DISPATCH) || (state_q == ST_DRAIN);
    assign frame_done_out       = (state_q == ST_DONE);
    assign unit_valid_out       = valid_q;
    assign unit_hcount_out      = hbus_q;
    assign unit_vcount_out      = vbus_q;
    assign unit_fractal_sel_out = sel_q;

    assign last_pix = (h_q == H_BITS'(DISPLAY_WIDTH - 1)) && (v_q == V_BITS'(DISPLAY_HEIGHT - 1));

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        h_d        = h_q;
        v_d        = v_q;
        hbus_d     = hbus_q;
        vbus_d     = vbus_q;
        rr_d       = rr_q;
        op_d       = op_q;
        busy_d     = busy_q;
        full_d     = full_q;
        valid_d    = '0;
        res_d      = res_q;
        hold_d     = pix_valid_out & ~pix_ready_in;
        hold_idx_d = out_idx;

        for (int i = 0; i < NUM_UNITS; i++) begin
            if (unit_done_in[i] && busy_q[i] && !full_q[i]) begin
                full_d[i]       = 1'b1;
                res_d[i].h      = RAY_H_BITS'(unit_hcount_in[i*H_BITS +: H_BITS]);
                res_d[i].v      = RAY_V_BITS'(unit_vcount_in[i*V_BITS +: V_BITS]);
                res_d[i].color  = RAY_COLOR_BITS'(unit_color_in[i*COLOR_BITS +: COLOR_BITS]);
            end
        end

        if (pix_fire) begin
            full_d[out_idx] = 1'b0;
            busy_d[out_idx] = 1'b0;
            op_d = (out_idx == PW'(NUM_UNITS - 1)) ? '0 : out_idx + PW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    state_d = ST_DISPATCH;
                    sel_d   = fractal_sel_in;
                    h_d     = '0;
                    v_d     = '0;
                end
            end
            ST_DISPATCH: begin
                if (iss_any) begin
                    valid_d = iss_gnt;
                    hbus_d  = h_q;
                    vbus_d  = v_q;
                    busy_d  = busy_d | iss_gnt;
                    rr_d    = (iss_idx == PW'(NUM_UNITS - 1)) ? '0 : iss_idx + PW'(1);
                    if (last_pix) begin
                        state_d = ST_DRAIN;
                    end else if (h_q == H_BITS'(DISPLAY_WIDTH - 1)) begin
                        h_d = '0;
                        v_d = v_q + V_BITS'(1);
                    end else begin
                        h_d = h_q + H_BITS'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (busy_q == '0 && full_q == '0) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            h_q        <= '0;
            v_q        <= '0;
            hbus_q     <= '0;
            vbus_q     <= '0;
            rr_q       <= '0;
            op_q       <= '0;
            busy_q     <= '0;
            full_q     <= '0;
            valid_q    <= '0;
            hold_q     <= 1'b0;
            hold_idx_q <= '0;
            for (int i = 0; i < NUM_UNITS; i++) res_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            h_q        <= h_d;
            v_q        <= v_d;
            hbus_q     <= hbus_d;
            vbus_q     <= vbus_d;
            rr_q       <= rr_d;
            op_q       <= op_d;
            busy_q     <= busy_d;
            full_q     <= full_d;
            valid_q    <= valid_d;
            hold_q     <= hold_d;
            hold_idx_q <= hold_idx_d;
            res_q      <= res_d;
        end
    end

endmodule

// File: doc/ray_dispatch.md
RAY_DISPATCH -- requirements
Module: ray_dispatch

Interface
REQ-001 SHALL have parameters: DISPLAY_WIDTH, default 400, pixels per line; DISPLAY_HEIGHT, default 300, lines per frame; H_BITS, default 9, hcount width; V_BITS, default 9, vcount width; NUM_UNITS, default 4, attached ray units; COLOR_BITS, default 4, color width.
REQ-002 SHALL have ports, one per line, in this order:
  clk_in  input  1  sole clock.
  rst_in  input  1  asynchronous, active-low reset.
  start_in  input  1  pulse that starts a frame.
  fractal_sel_in  input  3  fractal mode, sampled at start.
  busy_out  output  1  high while a frame is in progress.
  frame_done_out  output  1  one-cycle end-of-frame pulse.
  unit_valid_out  output  NUM_UNITS  one-hot job-issue pulse.
  unit_hcount_out  output  H_BITS  job pixel x, shared bus.
  unit_vcount_out  output  V_BITS  job pixel y, shared bus.
  unit_fractal_sel_out  output  3  latched mode, shared bus.
  unit_ready_in  input  NUM_UNITS  unit idle and able to accept a job.
  unit_done_in  input  NUM_UNITS  unit result-valid pulse.
  unit_hcount_in  input  NUM_UNITS*H_BITS  per-unit result x.
  unit_vcount_in  input  NUM_UNITS*V_BITS  per-unit result y.
  unit_color_in  input  NUM_UNITS*COLOR_BITS  per-unit result color.
  pix_valid_out  output  1  result available.
  pix_ready_in  input  1  downstream accepts the result.
  pix_hcount_out  output  H_BITS  result x.
  pix_vcount_out  output  V_BITS  result y.
  pix_color_out  output  COLOR_BITS  result color.

Function
REQ-003 The FSM SHALL have the states IDLE, DISPATCH, DRAIN and DONE.
REQ-004 IDLE->DISPATCH SHALL occur on start_in; the same edge latches fractal_sel_in and clears the pixel counter to (0,0).
REQ-005 start_in SHALL be ignored outside IDLE, and fractal_sel_in changes mid-frame SHALL have no effect.
REQ-006 In DISPATCH the block SHALL issue at most one job per cycle, to the first unit at or after the round-robin pointer with unit_ready_in=1 and busy bit 0.
REQ-007 Each issue SHALL be a registered one-cycle pulse on one unit_valid_out bit, with the current pixel on the shared buses.
REQ-008 Each issue SHALL set that unit's busy bit and move the round-robin pointer to the granted unit +1, mod NUM_UNITS.
REQ-009 The pixel counter SHALL advance in raster order: hcount wraps DISPLAY_WIDTH-1->0 with vcount+1.
REQ-010 Issuing pixel (DISPLAY_WIDTH-1, DISPLAY_HEIGHT-1) SHALL move the FSM to DRAIN; no further jobs are issued.
REQ-011 Each unit SHALL have a one-entry result register that captures x, y and color on unit_done_in.
REQ-012 unit_done_in from a unit whose busy bit is 0, or whose result register is already full, SHALL be dropped.
REQ-013 An output round-robin arbiter SHALL present one full result register on pix_*; pix_valid_out rises the cycle after capture at the earliest.
REQ-014 pix_* SHALL stay stable while pix_valid_out=1 and pix_ready_in=0.
REQ-015 On a pix handshake the block SHALL clear that result register and that unit's busy bit, and advance the output pointer.
REQ-016 Capture and handshake on the same unit in the same cycle SHALL NOT occur, because a busy unit has exactly one outstanding result.
REQ-017 DRAIN->DONE SHALL occur when all busy bits and all result registers are clear.
REQ-018 DONE SHALL pulse frame_done_out for one cycle and then enter IDLE.
REQ-019 busy_out SHALL be 1 in DISPATCH and DRAIN, and 0 otherwise.
REQ-020 With NUM_UNITS=1 the block SHALL degenerate to strict issue/collect alternation.

Reset
REQ-021 rst_in low SHALL asynchronously force IDLE and clear: the counters, both pointers, the busy bits, the result registers, unit_valid_out, pix_valid_out, frame_done_out and busy_out.
REQ-022 On reset the bus and pix data outputs SHALL be 0.
REQ-023 Reset mid-frame SHALL abandon the frame without emitting frame_done_out; late unit_done_in pulses SHALL then be dropped because all busy bits are 0.

Structure
REQ-024 The pixel-result typedef (h, v, color) and the FSM state enum SHALL live in the shared ray package, next to the vec3/fixed-point types.
REQ-025 One sub-module, rr_arbiter, parameterised on N, SHALL implement request vector plus pointer to one-hot grant, and SHALL be instanced twice: job issue and result output.

Verification
REQ-026 The bench SHALL cover these scenarios:
  Scenario 1: DISPLAY 4x2, NUM_UNITS=2; units done 3 cycles after issue; pix_ready_in=1 -> 8 results, each pixel exactly once, then a frame_done_out pulse.
  Scenario 2: As Scenario 1 with pix_ready_in low for 10 cycles -> dispatch stalls after 2 jobs; the held pix_* stay stable; the frame then completes.
  Scenario 3: unit 1 ready_in tied 0 -> all 8 jobs go to unit 0, in order (0,0),(1,0)...(3,1).
  Scenario 4: start_in during DISPATCH, and fractal_sel_in changed 2->5 mid-frame -> unit_fractal_sel_out stays 2; no restart.
  Scenario 5: rst_in low after 3 issues, with a done pulse arriving while in reset -> all outputs 0, state IDLE, no frame_done_out, the done is dropped.
  Scenario 6: Spurious unit_done_in on an idle unit -> no pix_valid_out.
